// File: rtl/seven_seg_capture_if.sv
// Bus bundle for seven_seg_capture.
//   master: display side driving segIn/anIn plus the frame consumer's frameAck;
//           observes valueOut/errOut/frameValid/overrun.
//   slave : the capture block itself.
interface seven_seg_capture_if #(
    parameter int NUM_DIGITS = 4
);
    logic [6:0]              segIn;       // segment lines, active low, bit6=g .. bit0=a
    logic [NUM_DIGITS-1:0]   anIn;        // digit enables, active low
    logic                    frameAck;    // consumer acknowledges presented frame
    logic [4*NUM_DIGITS-1:0] valueOut;    // captured frame, digit k at [4k+3:4k]
    logic [NUM_DIGITS-1:0]   errOut;      // per-digit undecodable-pattern flag
    logic                    frameValid;  // unacknowledged frame present
    logic                    overrun;     // sticky: complete frame dropped while valid

    modport master (
        output segIn, anIn, frameAck,
        input  valueOut, errOut, frameValid, overrun
    );

    modport slave (
        input  segIn, anIn, frameAck,
        output valueOut, errOut, frameValid, overrun
    );
endinterface

// File: rtl/seven_seg_capture.sv
// seven_seg_capture
//   Samples a multiplexed active-low seven-segment bus, recovers the hex nibble
//   on each digit once it has been stable for STABLE_CYCLES synchronized samples,
//   assembles a frame of NUM_DIGITS nibbles and presents it with valid/ack.
// Ports
//   clk    : system clock, rising edge
//   rst_n  : asynchronous reset, active low
//   bus    : seven_seg_capture_if.slave (segIn, anIn, frameAck in;
//            valueOut, errOut, frameValid, overrun out)
module seven_seg_capture #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seven_seg_capture_if.slave   bus
);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

    typedef enum logic {SCAN, HOLD} state_t;

    state_t state, stateNext;

    // Input synchronizers
    logic [6:0]            segS1, segS2;
    logic [NUM_DIGITS-1:0] anS1, anS2;

    // Digit selection
    logic [NUM_DIGITS-1:0] anLow;
    logic                  oneLow;
    logic [IW-1:0]         idx;

    // Stability tracking
    logic [IW-1:0] prevIdx;
    logic [6:0]    prevSeg;
    logic          prevValid;
    logic [CW-1:0] cnt, cntNext;
    logic          same;
    logic          accept;

    // Decode
    logic [3:0] nib;
    logic       nibErr;

    // Frame assembly
    logic [4*NUM_DIGITS-1:0] workVal;
    logic [NUM_DIGITS-1:0]   workErr;
    logic [NUM_DIGITS-1:0]   seen;
    logic                    complete;

    // Output registers
    logic [4*NUM_DIGITS-1:0] valueReg;
    logic [NUM_DIGITS-1:0]   errReg;
    logic                    overrunReg, overrunNext;
    logic                    load;

    function automatic logic [4:0] decodeSeg(input logic [6:0] p);
        logic [4:0] r;
        unique case (p)
            7'h40:   r = 5'h00;
            7'h79:   r = 5'h01;
            7'h24:   r = 5'h02;
            7'h30:   r = 5'h03;
            7'h19:   r = 5'h04;
            7'h12:   r = 5'h05;
            7'h02:   r = 5'h06;
            7'h78:   r = 5'h07;
            7'h00:   r = 5'h08;
            7'h18:   r = 5'h09;
            7'h08:   r = 5'h0A;
            7'h03:   r = 5'h0B;
            7'h46:   r = 5'h0C;
            7'h21:   r = 5'h0D;
            7'h06:   r = 5'h0E;
            7'h0E:   r = 5'h0F;
            default: r = 5'h10;   // err=1, nibble 0
        endcase
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            segS1 <= '0;
            segS2 <= '0;
            anS1  <= '0;
            anS2  <= '0;
        end else begin
            segS1 <= bus.segIn;
            segS2 <= segS1;
            anS1  <= bus.anIn;
            anS2  <= anS1;
        end
    end

    // Exactly one enable low selects a digit; anything else is blanking.
    always_comb begin
        anLow  = ~anS2;
        oneLow = (anLow != '0) && ((anLow & (anLow - 1'b1)) == '0);
        idx    = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (anLow[i]) idx = IW'(i);
        end
    end

    // cnt is the length of the current run of identical (idx, seg) samples,
    // saturating at STABLE_CYCLES. Accept fires on the sample that reaches the
    // limit, but not while an already-saturated run simply continues.
    always_comb begin
        same = prevValid && (idx == prevIdx) && (segS2 == prevSeg);
        if (!oneLow)
            cntNext = '0;
        else if (same)
            cntNext = (cnt == CNT_MAX) ? CNT_MAX : cnt + 1'b1;
        else
            cntNext = CW'(1);
        accept = oneLow && (cntNext == CNT_MAX) && !(same && (cnt == CNT_MAX));
        {nibErr, nib} = decodeSeg(segS2);
        complete = (seen == '1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prevIdx   <= '0;
            prevSeg   <= '0;
            prevValid <= 1'b0;
            cnt       <= '0;
        end else begin
            prevIdx   <= idx;
            prevSeg   <= segS2;
            prevValid <= oneLow;
            cnt       <= cntNext;
        end
    end

    // seen clears on completion; an accept in that same cycle starts the next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            workVal <= '0;
            workErr <= '0;
            seen    <= '0;
        end else begin
            if (complete) seen <= '0;
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                if (accept && (idx == IW'(i))) begin
                    workVal[4*i +: 4] <= nib;
                    workErr[i]        <= nibErr;
                    seen[i]           <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= SCAN;
        else        state <= stateNext;
    end

    always_comb begin
        stateNext   = state;
        load        = 1'b0;
        overrunNext = overrunReg;
        unique case (state)
            SCAN: begin
                if (complete) begin
                    load      = 1'b1;
                    stateNext = HOLD;
                end
            end
            HOLD: begin
                if (complete && bus.frameAck) begin
                    load        = 1'b1;
                    overrunNext = 1'b0;
                end else if (complete) begin
                    overrunNext = 1'b1;
                end else if (bus.frameAck) begin
                    overrunNext = 1'b0;
                    stateNext   = SCAN;
                end
            end
            default: stateNext = SCAN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valueReg   <= '0;
            errReg     <= '0;
            overrunReg <= 1'b0;
        end else begin
            overrunReg <= overrunNext;
            if (load) begin
                valueReg <= workVal;
                errReg   <= workErr;
            end
        end
    end

    assign bus.valueOut   = valueReg;
    assign bus.errOut     = errReg;
    assign bus.frameValid = (state == HOLD);
    assign bus.overrun    = overrunReg;
endmodule

// File: tb/tb_seven_seg_capture.sv
module tb_seven_seg_capture;
    localparam int ND = 4;

    logic clk;
    logic rst_n;
    int unsigned checkCnt;
    int unsigned failCnt;

    seven_seg_capture_if #(.NUM_DIGITS(ND)) bus ();

    seven_seg_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCnt++;
        if (got !== exp) begin
            failCnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic blank(input int n);
        bus.anIn  = '1;
        bus.segIn = 7'h7F;
        waitCycles(n);
    endtask

    task automatic driveDigit(input int k, input logic [6:0] pat, input int n);
        logic [ND-1:0] an;
        an        = '1;
        an[k]     = 1'b0;
        bus.anIn  = an;
        bus.segIn = pat;
        waitCycles(n);
    endtask

    // Drives four digits 8 cycles each, back to back, then blanks long enough
    // for the frame to be presented.
    task automatic scanFrame(input logic [6:0] p0, input logic [6:0] p1,
                             input logic [6:0] p2, input logic [6:0] p3);
        driveDigit(0, p0, 8);
        driveDigit(1, p1, 8);
        driveDigit(2, p2, 8);
        driveDigit(3, p3, 8);
        blank(10);
    endtask

    task automatic pulseAck();
        bus.frameAck = 1'b1;
        waitCycles(1);
        bus.frameAck = 1'b0;
        waitCycles(2);
    endtask

    initial begin
        checkCnt     = 0;
        failCnt      = 0;
        rst_n        = 1'b0;
        bus.anIn     = '1;
        bus.segIn    = 7'h7F;
        bus.frameAck = 1'b0;
        waitCycles(3);
        checkVal("rst_value", 32'(bus.valueOut), 32'h0);
        checkVal("rst_err", 32'(bus.errOut), 32'h0);
        checkVal("rst_valid", 32'(bus.frameValid), 32'h0);
        checkVal("rst_overrun", 32'(bus.overrun), 32'h0);
        rst_n = 1'b1;
        waitCycles(2);

        // Basic frame: 1,2,3,4 on digits 0..3
        scanFrame(7'h79, 7'h24, 7'h30, 7'h19);
        checkVal("t1_value", 32'(bus.valueOut), 32'h4321);
        checkVal("t1_err", 32'(bus.errOut), 32'h0);
        checkVal("t1_valid", 32'(bus.frameValid), 32'h1);
        pulseAck();
        checkVal("t1_ack_valid", 32'(bus.frameValid), 32'h0);

        // Undecodable pattern on digit 2: 0,6,err,7
        scanFrame(7'h40, 7'h02, 7'h7F, 7'h78);
        checkVal("t3_value", 32'(bus.valueOut), 32'h7060);
        checkVal("t3_err", 32'(bus.errOut), 32'h4);
        checkVal("t3_valid", 32'(bus.frameValid), 32'h1);
        pulseAck();

        // Short burst on digit 1 (3 samples) is not accepted; a 4-sample hold is.
        driveDigit(0, 7'h18, 8);
        blank(3);
        driveDigit(1, 7'h06, 3);
        blank(4);
        driveDigit(2, 7'h12, 8);
        driveDigit(3, 7'h40, 8);
        blank(10);
        checkVal("t2_short_valid", 32'(bus.frameValid), 32'h0);
        driveDigit(1, 7'h00, 4);
        blank(10);
        checkVal("t2_exact_valid", 32'(bus.frameValid), 32'h1);
        checkVal("t2_value", 32'(bus.valueOut), 32'h0589);
        pulseAck();

        // Two frames without ack: second is dropped
        scanFrame(7'h40, 7'h79, 7'h24, 7'h30);
        checkVal("t4_first_valid", 32'(bus.frameValid), 32'h1);
        checkVal("t4_first_overrun", 32'(bus.overrun), 32'h0);
        scanFrame(7'h08, 7'h03, 7'h46, 7'h21);
        checkVal("t4_value", 32'(bus.valueOut), 32'h3210);
        checkVal("t4_overrun", 32'(bus.overrun), 32'h1);
        checkVal("t4_valid", 32'(bus.frameValid), 32'h1);
        pulseAck();
        checkVal("t4_ack_valid", 32'(bus.frameValid), 32'h0);
        checkVal("t4_ack_overrun", 32'(bus.overrun), 32'h0);

        // Two digits lit: blanking, nothing accepted
        bus.anIn  = 4'b1100;
        bus.segIn = 7'h12;
        waitCycles(20);
        blank(5);
        checkVal("t5_blank_valid", 32'(bus.frameValid), 32'h0);
        scanFrame(7'h06, 7'h0E, 7'h12, 7'h00);
        checkVal("t5_valid", 32'(bus.frameValid), 32'h1);
        checkVal("t5_value", 32'(bus.valueOut), 32'h85FE);

        // Reset mid-frame while a frame is held
        driveDigit(0, 7'h79, 8);
        driveDigit(1, 7'h79, 8);
        driveDigit(2, 7'h79, 8);
        rst_n = 1'b0;
        blank(3);
        checkVal("t6_rst_value", 32'(bus.valueOut), 32'h0);
        checkVal("t6_rst_err", 32'(bus.errOut), 32'h0);
        checkVal("t6_rst_valid", 32'(bus.frameValid), 32'h0);
        checkVal("t6_rst_overrun", 32'(bus.overrun), 32'h0);
        rst_n = 1'b1;
        waitCycles(2);
        driveDigit(3, 7'h79, 8);
        blank(12);
        checkVal("t6_valid", 32'(bus.frameValid), 32'h0);
        checkVal("t6_value", 32'(bus.valueOut), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCnt, failCnt);
        $finish;
    end
endmodule
